// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external 2-port RAM (A write, B registered read) with a 2-entry output skid buffer.
// Empty-to-m_valid latency is 3 edges; s_ready drops when the RAM is full, m_valid holds data stable under m_ready stall.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    full,
    output logic                    empty,
    output logic                    ram_cen,
    output logic                    ram_wen_a,
    output logic [ADDR_WIDTH-1:0]   ram_addr_a,
    output logic [DATA_WIDTH-1:0]   ram_din_a,
    output logic                    ram_wen_b,
    output logic [DATA_WIDTH/8-1:0] ram_bwen_b,
    output logic [ADDR_WIDTH-1:0]   ram_addr_b,
    output logic [DATA_WIDTH-1:0]   ram_din_b,
    input  logic [DATA_WIDTH-1:0]   ram_dout_b
);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  mem_cnt;
    logic                  rd_pend;
    logic [1:0]            obuf_cnt;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;
    logic                  wr_en;
    logic                  pop;
    logic                  rd_issue;

    assign s_ready  = (mem_cnt != CNT_WIDTH'(DEPTH)) && !flush;
    assign wr_en    = s_valid && s_ready;
    assign m_valid  = (obuf_cnt != 2'd0);
    assign m_data   = obuf0;
    assign pop      = m_valid && m_ready && !flush;
    // Issue only if the word can land in the buffer alongside whatever is already pending.
    assign rd_issue = (mem_cnt != '0) && !flush &&
                      (({1'b0, obuf_cnt} + {2'b00, rd_pend} + 3'd1) <= (3'd2 + {2'b00, pop}));

    assign count = mem_cnt + CNT_WIDTH'(rd_pend) + CNT_WIDTH'(obuf_cnt);
    assign full  = (mem_cnt == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    assign ram_cen    = 1'b1;
    assign ram_wen_a  = wr_en && !reset;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = s_data;
    assign ram_wen_b  = 1'b0;
    assign ram_bwen_b = '0;
    assign ram_addr_b = rd_ptr;
    assign ram_din_b  = '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_issue)
                rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (wr_en && !rd_issue)
                mem_cnt <= mem_cnt + 1'b1;
            else if (!wr_en && rd_issue)
                mem_cnt <= mem_cnt - 1'b1;
            rd_pend <= rd_issue;

            if (rd_pend && pop) begin
                if (obuf_cnt == 2'd2) begin
                    obuf0 <= obuf1;
                    obuf1 <= ram_dout_b;
                end else begin
                    obuf0 <= ram_dout_b;
                end
            end else if (rd_pend) begin
                if (obuf_cnt == 2'd0)
                    obuf0 <= ram_dout_b;
                else
                    obuf1 <= ram_dout_b;
                obuf_cnt <= obuf_cnt + 2'd1;
            end else if (pop) begin
                obuf0    <= obuf1;
                obuf_cnt <= obuf_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 2-port RAM (registered read, read-before-write).
module tb_ram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ram_cen;
    logic          ram_wen_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_wen_b;
    logic [DW/8-1:0] ram_bwen_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b = '0;
    logic [DW-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .ram_cen(ram_cen), .ram_wen_a(ram_wen_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_wen_b(ram_wen_b), .ram_bwen_b(ram_bwen_b), .ram_addr_b(ram_addr_b),
        .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_cen && ram_wen_a)
            mem[ram_addr_a] <= ram_din_a;
        if (ram_cen)
            ram_dout_b <= mem[ram_addr_b];
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at 1 time unit later.
    task automatic drive(input logic f, input logic sv, input logic [31:0] sd, input logic mr);
        @(negedge clock);
        flush   = f;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_stream(input int n, input bit tog, input logic [31:0] base);
        logic [31:0] q[$];
        int          sent;
        int          recv;
        int          first;
        int          last;
        bit          prev_stall;
        logic [31:0] prev_dat;
        logic        sv;
        logic        mr;
        sent = 0; recv = 0; first = -1; last = -1; prev_stall = 0; prev_dat = '0;
        for (int cyc = 0; cyc < 600 && recv < n; cyc++) begin
            sv = (sent < n) && (tog ? 1'($urandom_range(0, 1)) : 1'b1);
            mr = tog ? (cyc % 2 == 0) : 1'b1;
            drive(1'b0, sv, base + 32'(sent), mr);
            if (prev_stall) begin
                check1("stall_valid", m_valid, 1'b1);
                check32("stall_data", m_data, prev_dat);
            end
            if (sv && s_ready) begin
                q.push_back(base + 32'(sent));
                sent++;
            end
            if (m_valid && mr) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_dup actual=%h required=none", m_data);
                end else begin
                    check32("stream_data", m_data, q.pop_front());
                end
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_stall = m_valid && !mr;
            prev_dat   = m_data;
        end
        check32("stream_count", 32'(recv), 32'(n));
        if (!tog)
            check32("stream_rate", 32'(last - first), 32'(n - 1));
    endtask

    typedef struct {
        logic        f;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] ec;
        logic        esr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int acc;
        int got;
        bit seen;

        // Expected values describe the state seen before the edge that applies the inputs.
        tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h00, 32'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'd1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h11, 32'd1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 32'h00, 32'd0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 32'h00, 32'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'd2, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h22, 32'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h22, 32'd2, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 32'd2, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 32'd1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h00, 32'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'd0, 1'b1};

        #1;
        check1("rst_m_valid", m_valid, 1'b0);
        check32("rst_m_data", m_data, 32'h0);
        check32("rst_count", 32'(count), 32'd0);
        check1("rst_empty", empty, 1'b1);
        check1("rst_full", full, 1'b0);
        check1("rst_s_ready", s_ready, 1'b1);
        check1("rst_wen_a", ram_wen_a, 1'b0);
        check1("ram_cen", ram_cen, 1'b1);
        check1("ram_wen_b", ram_wen_b, 1'b0);
        check32("ram_bwen_b", 32'(ram_bwen_b), 32'd0);
        check32("ram_din_b", ram_din_b, 32'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].f, tbl[i].sv, tbl[i].sd, tbl[i].mr);
            check1($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].ev);
            check32($sformatf("vec%0d_count", i), 32'(count), tbl[i].ec);
            check1($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].esr);
            check1($sformatf("vec%0d_empty", i), empty, tbl[i].ec == 32'd0);
            if (tbl[i].ev)
                check32($sformatf("vec%0d_m_data", i), m_data, tbl[i].ed);
        end

        // Fill with the sink stalled: 16 in RAM plus 2 in the output buffer.
        do_reset();
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            drive(1'b0, acc < 20, 32'(acc), 1'b0);
            if (s_valid && s_ready) acc++;
        end
        check32("fill_accepted", 32'(acc), 32'd18);
        check32("fill_count", 32'(count), 32'd18);
        check1("fill_full", full, 1'b1);
        check1("fill_s_ready", s_ready, 1'b0);
        got = 0;
        for (int c = 0; c < 60 && got < 18; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            if (m_valid) begin
                check32("drain_data", m_data, 32'(got));
                got++;
            end
        end
        check32("drain_words", 32'(got), 32'd18);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check1("drain_empty", empty, 1'b1);

        do_reset();
        run_stream(40, 1'b0, 32'h1000);
        do_reset();
        run_stream(40, 1'b1, 32'h2000);

        // Flush with five entries held and one read in flight.
        do_reset();
        for (int c = 0; c < 5; c++)
            drive(1'b0, 1'b1, 32'h50 + 32'(c), 1'b0);
        drive(1'b0, 1'b1, 32'h55, 1'b1);
        check32("preflush_head", m_data, 32'h50);
        drive(1'b1, 1'b1, 32'h99, 1'b1);
        check32("preflush_count", 32'(count), 32'd5);
        check1("flush_s_ready", s_ready, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check32("postflush_count", 32'(count), 32'd0);
        check1("postflush_m_valid", m_valid, 1'b0);
        drive(1'b0, 1'b1, 32'hAB, 1'b1);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            if (m_valid) begin
                check32("flush_first_word", m_data, 32'hAB);
                seen = 1;
            end
        end
        check1("flush_word_seen", seen, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            check1("postflush_idle_valid", m_valid, 1'b0);
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int c = 0; c < 6; c++)
            drive(1'b0, 1'b1, 32'h3000 + 32'(c), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check1("arst_m_valid", m_valid, 1'b0);
        check32("arst_m_data", m_data, 32'h0);
        check32("arst_count", 32'(count), 32'd0);
        check1("arst_empty", empty, 1'b1);
        check1("arst_full", full, 1'b0);
        check1("arst_s_ready", s_ready, 1'b1);
        check1("arst_wen_a", ram_wen_a, 1'b0);
        @(negedge clock);
        s_valid = 1'b0;
        reset   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            check1("arst_no_stale", m_valid, 1'b0);
        end
        drive(1'b0, 1'b1, 32'h77, 1'b1);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            if (m_valid) begin
                check32("arst_first_word", m_data, 32'h77);
                seen = 1;
            end
        end
        check1("arst_word_seen", seen, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
